// File: rtl/trigger_match_ctrl.sv
// trigger_match_ctrl
//   Sequences the two hardware triggers of the trigger CSR block. The
//   execute-stage PC and the memory-stage load/store address are compared
//   against each trigger's mcontrol/tdata2. A hit in cycle C is registered
//   and raised as a held request from C+1 until the pipeline acks or flushes.
//   After the ack, the resumed instruction (same PC) is skipped so the
//   trigger does not immediately re-fire.
//
// Ports
//   cpu_clk, cpu_rst        clock, async active-high reset
//   mctrl_t0/1, tdata2_t0/1 trigger configuration from the CSR block
//   exe_valid, exe_pc       execute-stage instruction
//   mem_ld_valid/st_valid   memory-stage load/store issue
//   mem_addr                memory-stage address
//   dbg_mode                hart in debug mode (blocks all matching)
//   pipe_flush, trig_ack    pipeline handshake
//   trig_req                held request to the pipeline
//   trig_action             0 = breakpoint exception, 1 = enter debug mode
//   trig_hit                triggers that fired
//   trig_tval               matched address
//   hit_set                 1-cycle pulse to set the tdata1 hit bit

// Per-trigger comparator: one instance per trigger.
module trigger_match_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           mctrl,
    input  logic [DATA_WIDTH-1:0] tdata2,
    input  logic                  exe_valid,
    input  logic [DATA_WIDTH-1:0] exe_pc,
    input  logic                  mem_ld_valid,
    input  logic                  mem_st_valid,
    input  logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  dbg_mode,
    output logic                  exe_hit,
    output logic                  mem_hit
);
    function automatic logic cmp(input logic [3:0] mt,
                                 input logic [DATA_WIDTH-1:0] a,
                                 input logic [DATA_WIDTH-1:0] t);
        case (mt)
            4'd0:    cmp = (a == t);
            4'd2:    cmp = (a >= t);
            4'd3:    cmp = (a < t);
            default: cmp = 1'b0;
        endcase
    endfunction

    logic dmode, action, m_en, ex_en, st_en, ld_en, eligible;
    logic [3:0] match;

    assign dmode  = mctrl[27];
    assign action = mctrl[12];
    assign match  = mctrl[10:7];
    assign m_en   = mctrl[6];
    assign ex_en  = mctrl[2];
    assign st_en  = mctrl[1];
    assign ld_en  = mctrl[0];

    // A debug-only trigger that asks for a breakpoint exception is malformed
    // and is never allowed to fire.
    assign eligible = ~(dmode & ~action) & m_en & ~dbg_mode;

    assign exe_hit = eligible & ex_en & exe_valid & cmp(match, exe_pc, tdata2);
    assign mem_hit = eligible & ((ld_en & mem_ld_valid) | (st_en & mem_st_valid))
                   & cmp(match, mem_addr, tdata2);

    // Fields not used by the comparator (chain is consumed at the top level).
    logic unused_mctrl;
    assign unused_mctrl = ^{mctrl[31:28], mctrl[26:13], mctrl[11], mctrl[5:3]};
endmodule

module trigger_match_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TRIG   = 2
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic [31:0]           mctrl_t0,
    input  logic [31:0]           mctrl_t1,
    input  logic [DATA_WIDTH-1:0] tdata2_t0,
    input  logic [DATA_WIDTH-1:0] tdata2_t1,
    input  logic                  exe_valid,
    input  logic [DATA_WIDTH-1:0] exe_pc,
    input  logic                  mem_ld_valid,
    input  logic                  mem_st_valid,
    input  logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  dbg_mode,
    input  logic                  pipe_flush,
    input  logic                  trig_ack,
    output logic                  trig_req,
    output logic                  trig_action,
    output logic [NUM_TRIG-1:0]   trig_hit,
    output logic [DATA_WIDTH-1:0] trig_tval,
    output logic [NUM_TRIG-1:0]   hit_set
);
    typedef enum logic [1:0] {IDLE, PEND, SKIP} state_t;

    typedef struct packed {
        logic [NUM_TRIG-1:0]   hit;
        logic [DATA_WIDTH-1:0] tval;
        logic                  action;
    } trig_rsp_t;

    logic [NUM_TRIG-1:0][31:0]           mctrl;
    logic [NUM_TRIG-1:0][DATA_WIDTH-1:0] tdata2;
    logic [NUM_TRIG-1:0]                 exe_hit, mem_hit;
    logic [NUM_TRIG-1:0]                 exe_fire, mem_fire, sel_fire;
    logic                                chain0, any_hit, release_skip;
    trig_rsp_t                           rsp_next;
    state_t                              state;

    assign mctrl  = {mctrl_t1, mctrl_t0};
    assign tdata2 = {tdata2_t1, tdata2_t0};

    generate
        for (genvar n = 0; n < NUM_TRIG; n++) begin : g_trig
            trigger_match_unit #(.DATA_WIDTH(DATA_WIDTH)) u_match (
                .mctrl        (mctrl[n]),
                .tdata2       (tdata2[n]),
                .exe_valid    (exe_valid),
                .exe_pc       (exe_pc),
                .mem_ld_valid (mem_ld_valid),
                .mem_st_valid (mem_st_valid),
                .mem_addr     (mem_addr),
                .dbg_mode     (dbg_mode),
                .exe_hit      (exe_hit[n]),
                .mem_hit      (mem_hit[n])
            );
        end
    endgenerate

    // Chaining gates trigger 0 on trigger 1 matching the same source in the
    // same cycle; trigger 1's own chain bit has no meaning with two triggers.
    assign chain0 = mctrl_t0[11];

    always_comb begin
        exe_fire    = exe_hit;
        mem_fire    = mem_hit;
        exe_fire[0] = exe_hit[0] & (~chain0 | exe_hit[1]);
        mem_fire[0] = mem_hit[0] & (~chain0 | mem_hit[1]);
    end

    // The memory-stage instruction is older, so its hits win and any
    // execute-stage hits in the same cycle are dropped.
    always_comb begin
        sel_fire      = (|mem_fire) ? mem_fire : exe_fire;
        any_hit       = |sel_fire;
        rsp_next.hit  = sel_fire;
        rsp_next.tval = (|mem_fire) ? mem_addr : exe_pc;
        // Lowest-index firing trigger decides; a chained pair uses trigger 1.
        if (sel_fire[0] && !chain0) rsp_next.action = mctrl_t0[12];
        else                        rsp_next.action = mctrl_t1[12];
    end

    // Leave SKIP on the first real instruction that is not the resumed one.
    assign release_skip = exe_valid & ~dbg_mode & (exe_pc != trig_tval);

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state       <= IDLE;
            trig_req    <= 1'b0;
            trig_hit    <= '0;
            trig_tval   <= '0;
            trig_action <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_hit) begin
                        state       <= PEND;
                        trig_req    <= 1'b1;
                        trig_hit    <= rsp_next.hit;
                        trig_tval   <= rsp_next.tval;
                        trig_action <= rsp_next.action;
                    end
                end
                PEND: begin
                    if (trig_ack) begin
                        state    <= SKIP;
                        trig_req <= 1'b0;
                    end else if (pipe_flush) begin
                        state     <= IDLE;
                        trig_req  <= 1'b0;
                        trig_hit  <= '0;
                        trig_tval <= '0;
                    end
                end
                SKIP: begin
                    // The releasing cycle is evaluated exactly as IDLE would.
                    if (release_skip) begin
                        if (any_hit) begin
                            state       <= PEND;
                            trig_req    <= 1'b1;
                            trig_hit    <= rsp_next.hit;
                            trig_tval   <= rsp_next.tval;
                            trig_action <= rsp_next.action;
                        end else begin
                            state     <= IDLE;
                            trig_hit  <= '0;
                            trig_tval <= '0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    trig_req <= 1'b0;
                end
            endcase
        end
    end

    // Hit bits are written back in the same cycle the pipeline takes the trap.
    always_comb begin
        hit_set = '0;
        if (state == PEND && trig_ack) hit_set = trig_hit;
    end
endmodule

// File: tb/tb_trigger_match_ctrl.sv
module tb_trigger_match_ctrl;
    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] mctrl_t0, mctrl_t1, tdata2_t0, tdata2_t1;
    logic        exe_valid, mem_ld_valid, mem_st_valid, dbg_mode, pipe_flush, trig_ack;
    logic [31:0] exe_pc, mem_addr;
    logic        trig_req, trig_action;
    logic [1:0]  trig_hit, hit_set;
    logic [31:0] trig_tval;

    int total = 0;
    int bad   = 0;

    always #5 cpu_clk = ~cpu_clk;

    trigger_match_ctrl dut (
        .cpu_clk      (cpu_clk),
        .cpu_rst      (cpu_rst),
        .mctrl_t0     (mctrl_t0),
        .mctrl_t1     (mctrl_t1),
        .tdata2_t0    (tdata2_t0),
        .tdata2_t1    (tdata2_t1),
        .exe_valid    (exe_valid),
        .exe_pc       (exe_pc),
        .mem_ld_valid (mem_ld_valid),
        .mem_st_valid (mem_st_valid),
        .mem_addr     (mem_addr),
        .dbg_mode     (dbg_mode),
        .pipe_flush   (pipe_flush),
        .trig_ack     (trig_ack),
        .trig_req     (trig_req),
        .trig_action  (trig_action),
        .trig_hit     (trig_hit),
        .trig_tval    (trig_tval),
        .hit_set      (hit_set)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle_inputs();
        exe_valid = 0; mem_ld_valid = 0; mem_st_valid = 0;
        pipe_flush = 0; trig_ack = 0; dbg_mode = 0;
    endtask

    // mcontrol encodings
    localparam logic [31:0] MC_T0_EXE_EQ   = 32'h0000_0044; // m, execute, match=0
    localparam logic [31:0] MC_T1_LD_GE_A1 = 32'h0000_1141; // action=1, match=2, m, load
    localparam logic [31:0] MC_T0_CH_EQ    = 32'h0000_0844; // chain, m, execute, match=0
    localparam logic [31:0] MC_T1_EXE_LT   = 32'h0000_11C4; // action=1, match=3, m, execute
    localparam logic [31:0] MC_T0_BAD      = 32'h0800_0044; // dmode=1, action=0

    initial begin
        cpu_rst = 1; idle_inputs();
        mctrl_t0 = 0; mctrl_t1 = 0; tdata2_t0 = 0; tdata2_t1 = 0;
        exe_pc = 0; mem_addr = 0;
        tick(); tick();
        chk("rst_req",  {31'd0, trig_req}, 0);
        chk("rst_hit",  {30'd0, trig_hit}, 0);
        chk("rst_tval", trig_tval, 0);
        chk("rst_act",  {31'd0, trig_action}, 0);
        cpu_rst = 0;

        // Basic execute hit, ack two cycles after req.
        mctrl_t0 = MC_T0_EXE_EQ; tdata2_t0 = 32'h1000;
        tick();
        exe_valid = 1; exe_pc = 32'h1000;           // cycle C
        tick();                                      // C+1
        exe_valid = 0;
        chk("c1_req",  {31'd0, trig_req}, 1);
        chk("c1_hit",  {30'd0, trig_hit}, 2'b01);
        chk("c1_tval", trig_tval, 32'h1000);
        chk("c1_act",  {31'd0, trig_action}, 0);
        tick();                                      // C+2
        chk("c2_req_held", {31'd0, trig_req}, 1);
        tick();                                      // C+3
        trig_ack = 1; #1;
        chk("c3_hit_set", {30'd0, hit_set}, 2'b01);
        tick();                                      // C+4
        trig_ack = 0;
        chk("c4_req", {31'd0, trig_req}, 0);
        chk("c4_hit_set", {30'd0, hit_set}, 0);
        chk("c4_hit_hold", {30'd0, trig_hit}, 2'b01);

        // SKIP: resumed PC ignored, different PC releases, then PC refires.
        exe_valid = 1; exe_pc = 32'h1000;
        tick();
        chk("skip_same_pc", {31'd0, trig_req}, 0);
        exe_pc = 32'h1004;
        tick();
        chk("skip_rel_req", {31'd0, trig_req}, 0);
        chk("skip_rel_hit", {30'd0, trig_hit}, 0);
        chk("skip_rel_tval", trig_tval, 0);
        exe_pc = 32'h1000;
        tick();
        chk("refire_req", {31'd0, trig_req}, 1);

        // Flush in PEND: no hit_set, back to IDLE, same PC refires.
        exe_valid = 0; pipe_flush = 1; #1;
        chk("flush_hit_set", {30'd0, hit_set}, 0);
        tick();
        pipe_flush = 0;
        chk("flush_req", {31'd0, trig_req}, 0);
        chk("flush_hit", {30'd0, trig_hit}, 0);
        exe_valid = 1; exe_pc = 32'h1000;
        tick();
        exe_valid = 0;
        chk("flush_refire", {31'd0, trig_req}, 1);

        // Ack and flush together: ack wins, SKIP holds hit.
        trig_ack = 1; pipe_flush = 1; #1;
        chk("ackflush_hit_set", {30'd0, hit_set}, 2'b01);
        tick();
        trig_ack = 0; pipe_flush = 0;
        chk("ackflush_req", {31'd0, trig_req}, 0);
        chk("ackflush_hold", {30'd0, trig_hit}, 2'b01);

        // Mem load hit beats a same-cycle exe hit; release SKIP first.
        mctrl_t1 = MC_T1_LD_GE_A1; tdata2_t1 = 32'h2000_0000;
        exe_valid = 1; exe_pc = 32'h1004;
        tick();
        exe_pc = 32'h1000; mem_ld_valid = 1; mem_addr = 32'h2000_0004;
        tick();
        exe_valid = 0; mem_ld_valid = 0;
        chk("mem_hit",  {30'd0, trig_hit}, 2'b10);
        chk("mem_tval", trig_tval, 32'h2000_0004);
        chk("mem_act",  {31'd0, trig_action}, 1);
        pipe_flush = 1; tick(); pipe_flush = 0;

        // Boundary: match=2 with addr == tdata2 fires.
        mem_ld_valid = 1; mem_addr = 32'h2000_0000;
        tick();
        mem_ld_valid = 0;
        chk("ge_equal", {30'd0, trig_hit}, 2'b10);
        pipe_flush = 1; tick(); pipe_flush = 0;

        // Chain: both match -> both bits, trigger 1's action.
        mctrl_t0 = MC_T0_CH_EQ; tdata2_t0 = 32'h100;
        mctrl_t1 = MC_T1_EXE_LT; tdata2_t1 = 32'h200;
        exe_valid = 1; exe_pc = 32'h100;
        tick();
        exe_valid = 0;
        chk("chain_hit", {30'd0, trig_hit}, 2'b11);
        chk("chain_act", {31'd0, trig_action}, 1);
        chk("chain_tval", trig_tval, 32'h100);
        pipe_flush = 1; tick(); pipe_flush = 0;
        tdata2_t1 = 32'h80;
        exe_valid = 1; exe_pc = 32'h100;
        tick();
        exe_valid = 0;
        chk("chain_broken", {31'd0, trig_req}, 0);

        // Ineligible: dmode=1 with action=0.
        mctrl_t0 = MC_T0_BAD; mctrl_t1 = 0; tdata2_t0 = 32'h1000;
        exe_valid = 1; exe_pc = 32'h1000;
        tick();
        exe_valid = 0;
        chk("dmode_act0", {31'd0, trig_req}, 0);

        // Debug mode blocks matching.
        mctrl_t0 = MC_T0_EXE_EQ;
        dbg_mode = 1; exe_valid = 1;
        tick();
        exe_valid = 0; dbg_mode = 0;
        chk("dbg_block", {31'd0, trig_req}, 0);

        // Reset while pending clears everything immediately.
        exe_valid = 1;
        tick();
        exe_valid = 0;
        chk("pre_rst_req", {31'd0, trig_req}, 1);
        trig_ack = 1; cpu_rst = 1; #1;
        chk("mid_rst_req", {31'd0, trig_req}, 0);
        chk("mid_rst_hit", {30'd0, trig_hit}, 0);
        chk("mid_rst_tval", trig_tval, 0);
        chk("mid_rst_hit_set", {30'd0, hit_set}, 0);
        tick();
        cpu_rst = 0; trig_ack = 0;
        tick();
        chk("post_rst_req", {31'd0, trig_req}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
